ascon_dec_fsm: RTL

//  Ascon-128 AEAD decryption/verification engine; receiving-side counterpart of the ascon_fsm encryptor.

---
 rtl/ascon_pkg.sv | 39 +++
 rtl/ascon_round.sv | 32 +++
 rtl/ascon_dec_fsm.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared Ascon definitions: state word type, IV, round constants, S-box table,
// round counts and the decryptor FSM state encoding.
package ascon_pkg;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  localparam logic [63:0] ASCON_IV = 64'h80400c0600000000;
  localparam int RATE = 64;
  localparam int PA   = 12;
  localparam int PB   = 6;

  localparam logic [7:0] RC [0:11] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  // Column index is {x0,x1,x2,x3,x4} bit, x0 as MSB.
  localparam logic [4:0] SBOX [0:31] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  typedef enum logic [2:0] {
    IDLE, LOAD, INIT, AD, DATA, FINAL, TAG, DONE
  } dec_state_e;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon permutation round: constant add, S-box layer,
// linear diffusion layer.
module ascon_round
  import ascon_pkg::*;
(
  input  logic [319:0] state_i,
  input  logic [7:0]   rc_i,
  output logic [319:0] state_o
);

  ascon_state_t s_c, s_s, s_l;
  logic [4:0]   col;

  always_comb begin
    s_c    = state_i;
    s_c.x2 = s_c.x2 ^ {56'd0, rc_i};
    s_s    = s_c;
    col    = '0;
    for (int b = 0; b < 64; b++) begin
      col = SBOX[{s_c.x0[b], s_c.x1[b], s_c.x2[b], s_c.x3[b], s_c.x4[b]}];
      {s_s.x0[b], s_s.x1[b], s_s.x2[b], s_s.x3[b], s_s.x4[b]} = col;
    end
    s_l.x0 = s_s.x0 ^ ror64(s_s.x0, 19) ^ ror64(s_s.x0, 28);
    s_l.x1 = s_s.x1 ^ ror64(s_s.x1, 61) ^ ror64(s_s.x1, 39);
    s_l.x2 = s_s.x2 ^ ror64(s_s.x2, 1)  ^ ror64(s_s.x2, 6);
    s_l.x3 = s_s.x3 ^ ror64(s_s.x3, 10) ^ ror64(s_s.x3, 17);
    s_l.x4 = s_s.x4 ^ ror64(s_s.x4, 7)  ^ ror64(s_s.x4, 41);
  end

  assign state_o = s_l;

endmodule

// File: rtl/ascon_dec_fsm.sv
// Ascon-128 decryption/verification engine, one permutation round per clock.
// Build option ASCON_DEC_MASK_EN: withhold plaintext until the tag verifies.
module ascon_dec_fsm
  import ascon_pkg::*;
#(
  parameter int NB_BLOCKS = 23
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [64*NB_BLOCKS-1:0] cipher_i,
  input  logic [127:0]            key_i,
  input  logic [127:0]            nonce_i,
  input  logic [63:0]             da_i,
  input  logic [127:0]            tag_i,
  output logic [64*NB_BLOCKS-1:0] plain_text_o,
  output logic [127:0]            tag_o,
  output logic                    tag_ok_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int W  = 64 * NB_BLOCKS;
  localparam int BW = (NB_BLOCKS > 1) ? $clog2(NB_BLOCKS) : 1;
  localparam logic [BW-1:0] LAST_BLK = BW'(NB_BLOCKS - 1);

  dec_state_e   state_q, state_d;
  ascon_state_t x_q, x_d, x_rnd;
  logic [319:0] x_rnd_flat;
  logic [3:0]   rnd_q, rnd_d, rc_idx;
  logic [BW-1:0] blk_q, blk_d, nxt_idx;
  logic [W-1:0] cipher_q, cipher_d, plain_q, plain_d;
  logic [127:0] key_q, key_d, tagi_q, tagi_d, tag_q, tag_d;
  logic [63:0]  da_q, da_d, cblk;
  logic         tag_ok_q, tag_ok_d, last_rnd, long_perm;

  assign long_perm = (state_q == INIT) || (state_q == FINAL);
  assign rc_idx    = long_perm ? rnd_q : rnd_q + 4'd6;
  assign last_rnd  = long_perm ? (rnd_q == 4'(PA - 1)) : (rnd_q == 4'(PB - 1));
  // Block n is absorbed on the edge that ends the previous phase, so AD picks up block 0.
  assign nxt_idx   = (state_q == AD) ? '0 : blk_q + BW'(1);
  assign cblk      = cipher_q[W-1-64*int'(nxt_idx) -: 64];

  ascon_round u_round (
    .state_i (x_q),
    .rc_i    (RC[rc_idx]),
    .state_o (x_rnd_flat)
  );
  assign x_rnd = x_rnd_flat;

  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_i) state_d = LOAD;
      LOAD:  state_d = INIT;
      INIT:  if (last_rnd) state_d = AD;
      AD:    if (last_rnd) state_d = (NB_BLOCKS == 1) ? FINAL : DATA;
      DATA:  if (last_rnd && nxt_idx == LAST_BLK) state_d = FINAL;
      FINAL: if (last_rnd) state_d = TAG;
      TAG:   state_d = DONE;
      DONE:  if (!start_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (state_q != IDLE) && (state_q != DONE);
    done_o   = (state_q == DONE);
    tag_o    = tag_q;
    tag_ok_o = tag_ok_q;
`ifdef ASCON_DEC_MASK_EN
    plain_text_o = (done_o && tag_ok_q) ? plain_q : '0;
`else
    plain_text_o = plain_q;
`endif
  end

  always_comb begin
    x_d      = x_q;
    rnd_d    = rnd_q;
    blk_d    = blk_q;
    cipher_d = cipher_q;
    plain_d  = plain_q;
    key_d    = key_q;
    tagi_d   = tagi_q;
    da_d     = da_q;
    tag_d    = tag_q;
    tag_ok_d = tag_ok_q;
    unique case (state_q)
      LOAD: begin
        cipher_d = cipher_i;
        key_d    = key_i;
        tagi_d   = tag_i;
        da_d     = da_i;
        x_d      = {ASCON_IV, key_i, nonce_i};
        rnd_d    = '0;
        blk_d    = '0;
        plain_d  = '0;
        tag_d    = '0;
        tag_ok_d = 1'b0;
      end
      INIT, AD, DATA, FINAL: begin
        x_d   = x_rnd;
        rnd_d = rnd_q + 4'd1;
        if (last_rnd) begin
          rnd_d = '0;
          if (state_q == INIT) begin
            x_d.x3 = x_d.x3 ^ key_q[127:64];
            x_d.x4 = x_d.x4 ^ key_q[63:0];
            x_d.x0 = x_d.x0 ^ da_q;
          end else if (state_q == FINAL) begin
            tag_d = {x_d.x3, x_d.x4} ^ key_q;
          end else begin
            if (state_q == AD) x_d.x4 = x_d.x4 ^ 64'd1;
            plain_d[W-1-64*int'(nxt_idx) -: 64] = x_d.x0 ^ cblk;
            x_d.x0 = cblk;
            blk_d  = nxt_idx;
            if (nxt_idx == LAST_BLK) begin
              x_d.x1 = x_d.x1 ^ key_q[127:64];
              x_d.x2 = x_d.x2 ^ key_q[63:0];
            end
          end
        end
      end
      TAG:     tag_ok_d = (tag_q == tagi_q);
      default: ;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      x_q      <= '0;
      rnd_q    <= '0;
      blk_q    <= '0;
      cipher_q <= '0;
      plain_q  <= '0;
      key_q    <= '0;
      tagi_q   <= '0;
      da_q     <= '0;
      tag_q    <= '0;
      tag_ok_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      rnd_q    <= rnd_d;
      blk_q    <= blk_d;
      cipher_q <= cipher_d;
      plain_q  <= plain_d;
      key_q    <= key_d;
      tagi_q   <= tagi_d;
      da_q     <= da_d;
      tag_q    <= tag_d;
      tag_ok_q <= tag_ok_d;
    end
  end

endmodule
